// File: rtl/instruction_sequencer_if.sv
// ---------------------------------------------------------------------------
// instruction_sequencer_if
// Groups the sequencer's host-side and coprocessor-side signals.
//   Host side     : instr_in (opcode), start_in (request level),
//                   busy, done_flag, error_flag, err_code (status)
//   Coprocessor   : op_code, op_valid (command), op_ready, op_done
// Modports:
//   master : the sequencer itself (drives command and status)
//   slave  : the environment (host PIOs plus coprocessor)
// ---------------------------------------------------------------------------
interface instruction_sequencer_if;

    logic [2:0] instr_in;
    logic       start_in;
    logic       op_ready;
    logic       op_done;

    logic [2:0] op_code;
    logic       op_valid;
    logic       busy;
    logic       done_flag;
    logic       error_flag;
    logic [1:0] err_code;

    modport master (
        input  instr_in,
        input  start_in,
        input  op_ready,
        input  op_done,
        output op_code,
        output op_valid,
        output busy,
        output done_flag,
        output error_flag,
        output err_code
    );

    modport slave (
        output instr_in,
        output start_in,
        output op_ready,
        output op_done,
        input  op_code,
        input  op_valid,
        input  busy,
        input  done_flag,
        input  error_flag,
        input  err_code
    );

endinterface

// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
// Accepts a start request from the host, checks the opcode against a mask of
// executable opcodes, hands the command to a coprocessor with a valid/ready
// handshake, then waits (bounded by a timeout) for the coprocessor's done
// pulse and reports completion or failure through sticky status flags.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : instruction_sequencer_if.master
//            instr_in[2:0] in  : opcode from host
//            start_in      in  : 0->1 requests execution
//            op_ready      in  : coprocessor accepts command
//            op_done       in  : coprocessor completion pulse
//            op_code[2:0]  out : latched opcode
//            op_valid      out : command valid
//            busy          out : not idle
//            done_flag     out : sticky, last command completed
//            error_flag    out : sticky, last request failed
//            err_code[1:0] out : 00 none, 01 invalid opcode, 10 timeout
//
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in WAIT, 1 .. 2^24-1
//   VALID_MASK     : bit n set marks opcode n as executable
// ---------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  VALID_MASK     = 8'b0011_1110
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_sequencer_if.master bus
);

    localparam int unsigned CNT_W = 24;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Last WAIT cycle count before the timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0]       state_q,      state_d;
    logic             start_q,      start_d;
    logic [2:0]       op_code_q,    op_code_d;
    logic             op_valid_q,   op_valid_d;
    logic             busy_q,       busy_d;
    logic             done_flag_q,  done_flag_d;
    logic             error_flag_q, error_flag_d;
    logic [1:0]       err_code_q,   err_code_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic             start_rise;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            op_code_q    <= 3'd0;
            op_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_flag_q  <= 1'b0;
            error_flag_q <= 1'b0;
            err_code_q   <= ERR_NONE;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            op_code_q    <= op_code_d;
            op_valid_q   <= op_valid_d;
            busy_q       <= busy_d;
            done_flag_q  <= done_flag_d;
            error_flag_q <= error_flag_d;
            err_code_q   <= err_code_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        op_code_d    = op_code_q;
        done_flag_d  = done_flag_q;
        error_flag_d = error_flag_q;
        err_code_d   = err_code_q;
        cnt_d        = cnt_q;
        start_d      = bus.start_in;

        // start_q clears in reset, so a level already high at release is an edge.
        start_rise   = bus.start_in & ~start_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    op_code_d    = bus.instr_in;
                    done_flag_d  = 1'b0;
                    error_flag_d = 1'b0;
                    err_code_d   = ERR_NONE;
                    if (VALID_MASK[bus.instr_in]) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Error status is shown on ERROR entry, together with its code.
                        state_d      = S_ERROR;
                        error_flag_d = 1'b1;
                        err_code_d   = ERR_OPCODE;
                    end
                end
            end

            S_ISSUE: begin
                // No timeout here: hold the command until it is taken.
                if (op_valid_q && bus.op_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            S_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // op_done takes priority over a simultaneous timeout.
                if (bus.op_done) begin
                    state_d = S_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d      = S_ERROR;
                    error_flag_d = 1'b1;
                    err_code_d   = ERR_TIMEOUT;
                end
            end

            S_DONE: begin
                // done_flag lands on the way back to IDLE (2 cycles after op_done).
                state_d     = S_IDLE;
                done_flag_d = 1'b1;
            end

            S_ERROR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        op_valid_d = (state_d == S_ISSUE);
        busy_d     = (state_d != S_IDLE);
    end

    assign bus.op_code    = op_code_q;
    assign bus.op_valid   = op_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done_flag  = done_flag_q;
    assign bus.error_flag = error_flag_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: max cycles in WAIT before timeout error; legal range 1 to 2^24-1.
REQ-002 Parameter VALID_MASK, default 8'b0011_1110: bit n set SHALL mark opcode n as executable.
REQ-003 clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr_in  input  3  opcode from the instruction PIO output port.
REQ-006 start_in  input  1  level from the HPS control PIO; a 0->1 transition requests execution.
REQ-007 op_ready  input  1  coprocessor can accept a command this cycle.
REQ-008 op_done  input  1  one-cycle pulse when the coprocessor finishes the accepted command.
REQ-009 op_code  output  3  latched opcode presented to the coprocessor.
REQ-010 op_valid  output  1  command valid; transfer occurs when op_valid and op_ready are both high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done_flag  output  1  sticky, last command completed.
REQ-013 error_flag  output  1  sticky, last request failed.
REQ-014 err_code  output  2  00 none, 01 invalid opcode, 10 timeout.

Function
REQ-015 start_in SHALL be registered once; start_rise = start_in & ~start_q, where start_q is the registered value.
REQ-016 The block SHALL have five states: IDLE, ISSUE, WAIT, DONE, ERROR.
REQ-017 IDLE on start_rise: latch instr_in into op_code, clear done_flag, error_flag and err_code in the same edge.
- Go to ISSUE if VALID_MASK[instr_in]=1.
- Otherwise go to ERROR with err_code=01.
REQ-018 ISSUE: op_valid=1; op_code SHALL be stable while op_valid is high; on op_valid&op_ready, go to WAIT next cycle and load the timeout counter with 0.
REQ-019 ISSUE has no timeout; op_valid SHALL stay high until the handshake completes.
REQ-020 WAIT: op_valid=0.
- Counter SHALL increment by 1 per cycle.
- On op_done, go to DONE.
- If the counter reaches TIMEOUT_CYCLES-1 without op_done, go to ERROR with err_code=10.
REQ-021 If op_done and the timeout condition occur in the same cycle, op_done SHALL win (go to DONE).
REQ-022 The counter SHALL be 24 bits wide, SHALL saturate and never wrap, and SHALL be cleared on WAIT entry.
REQ-023 DONE: set done_flag=1 and return to IDLE after one cycle.
REQ-024 ERROR: set error_flag=1 and return to IDLE after one cycle.
REQ-025 op_done pulses outside WAIT SHALL be ignored.
REQ-026 start_rise outside IDLE SHALL be ignored and not queued; changes on instr_in outside IDLE SHALL not affect op_code.
REQ-027 busy SHALL go high on the cycle after the accepting start_rise edge.
- Minimum request-to-op_valid latency: 1 cycle after start_rise is sampled.
- Minimum op_done-to-done_flag latency: 2 cycles.
REQ-028 Opcode 0 with VALID_MASK bit 0 clear SHALL produce an invalid-opcode error and SHALL NOT assert op_valid.

Reset
REQ-029 While reset is high, all of the following SHALL hold regardless of clk: state=IDLE, op_code=0, op_valid=0, busy=0, done_flag=0, error_flag=0, err_code=00, counter=0, start_q=0.
REQ-030 Reset asserted mid-operation (ISSUE or WAIT) SHALL abort the command with no done or error flag set; a later op_done SHALL be ignored.
REQ-031 If start_in is already high when reset is released, this SHALL count as a rising edge and SHALL be accepted on the first clock edge after reset is released.

Verification
REQ-032 instr_in=3, start 0->1, op_ready=1, op_done 5 cycles later -> op_valid high exactly 1 cycle with op_code=3; done_flag=1; err_code=00; busy low again.
REQ-033 instr_in=7, start 0->1 -> op_valid never asserts; error_flag=1; err_code=01 within 2 cycles.
REQ-034 TIMEOUT_CYCLES=16, valid opcode, op_done never asserted -> error_flag=1, err_code=10 exactly 16 cycles after WAIT entry.
REQ-035 op_ready held low 10 cycles -> op_valid and op_code stable for 10 cycles; second start edge and instr_in change during this time ignored.
REQ-036 op_done and timeout in the same cycle -> done_flag=1, error_flag=0.
REQ-037 Reset pulsed in WAIT, then op_done -> all outputs 0, state IDLE, no flag set.
